picomips_host: RTL and testbench

Host-side operand sequencer for the picoMIPS core. It drives the core's switch-input interface: data on SW[7:0] and the SW[8] operand-ready handshake. It presents an x/y operand pair through that handshake, then watches the core's LED output and captures the result once LED has settled. It sits between a test or upstream controller and the picoMIPS SW/LED pins, and replaces the human operating the switches.

---
 rtl/picomips_host_pkg.sv | 28 ++
 rtl/led_settle_det.sv | 54 +++++
 rtl/picomips_host.sv | 174 +++++++++++++++++
 tb/tb_picomips_host.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/picomips_host_pkg.sv
// Shared types and default constants for the picoMIPS host sequencer.
package picomips_host_pkg;

  localparam int DEF_N           = 8;
  localparam int DEF_HOLD_CYC    = 4;
  localparam int DEF_GAP_CYC     = 2;
  localparam int DEF_STABLE_CYC  = 3;
  localparam int DEF_TIMEOUT_CYC = 1000;

  // Position of the operand-ready strobe on the core's switch bus (SW[8]).
  localparam int HANDSHAKE_BIT   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP_X,
    PRES_X,
    REL_X,
    SETUP_Y,
    PRES_Y,
    REL_Y,
    WAIT
  } host_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_settle_det.sv
// Watches the core LED bus and flags when it has stayed constant long enough
// (settled) or when the overall wait budget has run out (expired).
module led_settle_det
  import picomips_host_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,     // entry into WAIT: snapshot led, clear counters
  input  logic         en,       // high while the host sits in WAIT
  input  logic [N-1:0] led,
  output logic         settled,  // this edge completes the stable run
  output logic         expired   // this edge exhausts the wait budget
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [N-1:0]  led_q;
  logic [CW-1:0] stable_q;
  logic [CW-1:0] wait_q;
  logic          same;

  assign same    = (led == led_q);
  // Pulses describe what the coming edge will do, so the FSM can act on it.
  assign settled = en && same && (stable_q == CW'(STABLE_CYC - 1));
  assign expired = en && (wait_q == CW'(TIMEOUT_CYC - 1));

  // Track the last LED value and count consecutive matches and total wait.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      led_q    <= '0;
      stable_q <= '0;
      wait_q   <= '0;
    end else if (load) begin
      led_q    <= led;
      stable_q <= '0;
      wait_q   <= '0;
    end else if (en) begin
      if (same) begin
        if (stable_q != {CW{1'b1}}) stable_q <= stable_q + CW'(1);
      end else begin
        stable_q <= '0;
        led_q    <= led;
      end
      if (wait_q != {CW{1'b1}}) wait_q <= wait_q + CW'(1);
    end
  end

endmodule

// File: rtl/picomips_host.sv
// Host-side operand sequencer: strobes x then y onto the picoMIPS switch bus,
// then captures the LED result once it has settled (or the wait times out).
module picomips_host
  import picomips_host_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  input  logic [N-1:0] led,
  output logic [N:0]   sw,
  output logic         busy,
  output logic [N-1:0] result,
  output logic         done,
  output logic         timeout
);

  localparam int PW = $clog2(max2(HOLD_CYC, GAP_CYC) + 1);

  host_state_t   state_q,   state_d;
  logic [PW-1:0] phase_q,   phase_d;
  logic [N-1:0]  x_q,       x_d;
  logic [N-1:0]  y_q,       y_d;
  logic [N:0]    sw_q,      sw_d;
  logic [N-1:0]  result_q,  result_d;
  logic          done_q,    done_d;
  logic          busy_q,    busy_d;
  logic          timeout_q, timeout_d;
  logic          det_load;
  logic          settled;
  logic          expired;

  led_settle_det #(
    .N           (N),
    .STABLE_CYC  (STABLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_det (
    .clk     (clk),
    .reset   (reset),
    .load    (det_load),
    .en      (state_q == WAIT),
    .led     (led),
    .settled (settled),
    .expired (expired)
  );

  // Next-state and registered-output logic; sw is set on entry to each state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    x_d       = x_q;
    y_d       = y_q;
    sw_d      = sw_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    timeout_d = timeout_q;
    det_load  = 1'b0;

    unique case (state_q)
      IDLE: begin
        sw_d[N] = 1'b0;
        if (start) begin
          x_d       = x_in;
          y_d       = y_in;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          sw_d      = {1'b0, x_in};
          state_d   = SETUP_X;
        end
      end
      SETUP_X: begin
        sw_d    = {1'b1, x_q};
        phase_d = PW'(HOLD_CYC - 1);
        state_d = PRES_X;
      end
      PRES_X: begin
        if (phase_q == '0) begin
          sw_d    = {1'b0, x_q};
          phase_d = PW'(GAP_CYC - 1);
          state_d = REL_X;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      REL_X: begin
        if (phase_q == '0) begin
          sw_d    = {1'b0, y_q};
          state_d = SETUP_Y;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      SETUP_Y: begin
        sw_d    = {1'b1, y_q};
        phase_d = PW'(HOLD_CYC - 1);
        state_d = PRES_Y;
      end
      PRES_Y: begin
        if (phase_q == '0) begin
          sw_d    = {1'b0, y_q};
          phase_d = PW'(GAP_CYC - 1);
          state_d = REL_Y;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      REL_Y: begin
        if (phase_q == '0) begin
          det_load = 1'b1;
          state_d  = WAIT;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      WAIT: begin
        // Stability is tested first so it wins a tie with the timeout.
        if (settled) begin
          result_d = led;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (expired) begin
          result_d  = led;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops the strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      sw_q      <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sw_q      <= sw_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sw      = sw_q;
  assign busy    = busy_q;
  assign result  = result_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_picomips_host.sv
// Directed bench for picomips_host: reset, handshake timing, LED settling,
// timeout, ignored start and back-to-back requests.
module tb_picomips_host;
  import picomips_host_pkg::*;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int S  = 3;
  localparam int W  = 2 * H + 2 * G + 2;  // WAIT entry edge
  localparam int TO = 20;                  // timeout for the second instance

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start_to;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic [7:0] led;

  logic [8:0] sw,     sw_t;
  logic       busy,   busy_t;
  logic [7:0] result, result_t;
  logic       done,   done_t;
  logic       timeout, timeout_t;

  int n_checks = 0;
  int n_fail   = 0;

  picomips_host u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .x_in    (x_in),
    .y_in    (y_in),
    .led     (led),
    .sw      (sw),
    .busy    (busy),
    .result  (result),
    .done    (done),
    .timeout (timeout)
  );

  picomips_host #(.TIMEOUT_CYC(TO)) u_dut_to (
    .clk     (clk),
    .reset   (reset),
    .start   (start_to),
    .x_in    (x_in),
    .y_in    (y_in),
    .led     (led),
    .sw      (sw_t),
    .busy    (busy_t),
    .result  (result_t),
    .done    (done_t),
    .timeout (timeout_t)
  );

  always #5 clk = ~clk;

  // One rising edge, then park at the falling edge to sample and drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if (sw !== 9'h000) begin n_fail++; $display("FAIL reset_sw got %h want 000", sw); end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got busy=%b done=%b timeout=%b want 0", busy, done, timeout);
    end
    n_checks++;
    if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
    reset = 1'b0;
    // Run into PRES_X, then hit reset between edges.
    x_in = 8'hA5; y_in = 8'h5A; led = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sw !== 9'h1A5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pres_x got sw=%h busy=%b want 1a5 1", sw, busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (sw !== 9'h000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_async got sw=%h busy=%b done=%b want 000 0 0", sw, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++;
    if (u_dut.state_q !== IDLE || sw !== 9'h000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle got state=%0d sw=%h busy=%b want IDLE 000 0", u_dut.state_q, sw, busy);
    end
  endtask

  task automatic test_basic();
    logic [8:0] exp_sw;
    x_in = 8'h05; y_in = 8'h03; led = 8'h08; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (sw !== 9'h005 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_e0 got sw=%h busy=%b want 005 1", sw, busy);
    end
    for (int k = 1; k <= W + S + 1; k++) begin
      tick();
      exp_sw[8]   = ((k >= 1) && (k <= H)) || ((k >= H + G + 2) && (k <= 2 * H + G + 1));
      exp_sw[7:0] = (k < H + G + 1) ? 8'h05 : 8'h03;
      n_checks++;
      if (sw !== exp_sw) begin n_fail++; $display("FAIL basic_sw k=%0d got %h want %h", k, sw, exp_sw); end
      n_checks++;
      if (done !== (k == W + S)) begin n_fail++; $display("FAIL basic_done k=%0d got %b want %b", k, done, (k == W + S)); end
      n_checks++;
      if (busy !== (k < W + S)) begin n_fail++; $display("FAIL basic_busy k=%0d got %b want %b", k, busy, (k < W + S)); end
    end
    n_checks++;
    if (result !== 8'h08 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL basic_result got %h timeout=%b want 08 0", result, timeout);
    end
  endtask

  task automatic test_led_toggle();
    x_in = 8'h01; y_in = 8'h02; led = 8'h08; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W; k++) tick();
    // Changes seen at edges W+1..W+4; last change at W+4, done S edges later.
    for (int k = W + 1; k <= W + 4 + S; k++) begin
      if (k <= W + 4) led = ((k - W) % 2 == 1) ? 8'h00 : 8'h08;
      tick();
      n_checks++;
      if (done !== (k == W + 4 + S)) begin
        n_fail++; $display("FAIL toggle_done k=%0d got %b want %b", k, done, (k == W + 4 + S));
      end
    end
    n_checks++;
    if (result !== 8'h08 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL toggle_result got %h timeout=%b busy=%b want 08 0 0", result, timeout, busy);
    end
    led = 8'h11;
    tick();
    tick();
    n_checks++;
    if (result !== 8'h08) begin n_fail++; $display("FAIL toggle_hold got %h want 08", result); end
  endtask

  task automatic test_timeout();
    x_in = 8'h21; y_in = 8'h12; led = 8'hC3; start_to = 1'b1;
    tick();
    start_to = 1'b0;
    for (int k = 1; k <= W + TO; k++) begin
      led = (k % 2 == 0) ? 8'hC3 : 8'h3C;
      tick();
      if (k > W) begin
        n_checks++;
        if (done_t !== (k == W + TO)) begin
          n_fail++; $display("FAIL timeout_done k=%0d got %b want %b", k, done_t, (k == W + TO));
        end
      end
    end
    n_checks++;
    if (timeout_t !== 1'b1 || busy_t !== 1'b0 || result_t !== 8'hC3) begin
      n_fail++; $display("FAIL timeout_flags got timeout=%b busy=%b result=%h want 1 0 c3", timeout_t, busy_t, result_t);
    end
    led = 8'h77;
    tick();
    n_checks++;
    if (done_t !== 1'b0 || timeout_t !== 1'b1) begin
      n_fail++; $display("FAIL timeout_hold got done=%b timeout=%b want 0 1", done_t, timeout_t);
    end
    start_to = 1'b1;
    tick();
    start_to = 1'b0;
    n_checks++;
    if (timeout_t !== 1'b0 || busy_t !== 1'b1) begin
      n_fail++; $display("FAIL timeout_clear got timeout=%b busy=%b want 0 1", timeout_t, busy_t);
    end
    for (int k = 1; k <= W + S; k++) tick();
    n_checks++;
    if (done_t !== 1'b1 || timeout_t !== 1'b0 || result_t !== 8'h77) begin
      n_fail++; $display("FAIL timeout_rerun got done=%b timeout=%b result=%h want 1 0 77", done_t, timeout_t, result_t);
    end
  endtask

  task automatic test_ignore_start();
    x_in = 8'h11; y_in = 8'h22; led = 8'h08; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= W + S + 2; k++) begin
      if (k == H + G + 3) begin start = 1'b1; x_in = 8'hEE; y_in = 8'hDD; end
      else start = 1'b0;
      tick();
      if (k >= H + G + 2 && k <= 2 * H + G + 1) begin
        n_checks++;
        if (sw !== 9'h122) begin n_fail++; $display("FAIL ignore_y k=%0d got %h want 122", k, sw); end
      end
      if (k > W + S) begin
        n_checks++;
        if (busy !== 1'b0 || sw[HANDSHAKE_BIT] !== 1'b0) begin
          n_fail++; $display("FAIL ignore_idle k=%0d got busy=%b strobe=%b want 0 0", k, busy, sw[HANDSHAKE_BIT]);
        end
      end
    end
    n_checks++;
    if (result !== 8'h08) begin n_fail++; $display("FAIL ignore_result got %h want 08", result); end
  endtask

  task automatic test_back_to_back();
    x_in = 8'h0A; y_in = 8'h0B; led = 8'h08; start = 1'b1;
    tick();
    for (int k = 1; k <= W + S; k++) tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done1 got done=%b busy=%b want 1 0", done, busy);
    end
    tick();  // done edge + 1: second request accepted
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sw !== 9'h00A) begin
      n_fail++; $display("FAIL b2b_accept got busy=%b done=%b sw=%h want 1 0 00a", busy, done, sw);
    end
    tick();  // done edge + 2: strobe rises
    n_checks++;
    if (sw !== 9'h10A) begin n_fail++; $display("FAIL b2b_strobe got %h want 10a", sw); end
    for (int k = 2; k <= W + S; k++) tick();
    n_checks++;
    if (done !== 1'b1 || result !== 8'h08) begin
      n_fail++; $display("FAIL b2b_done2 got done=%b result=%h want 1 08", done, result);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_to = 1'b0;
    x_in = '0; y_in = '0; led = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_led_toggle();
    test_timeout();
    test_ignore_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
